mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 4:1 single-bit mux (mux4_1) among four requesters.
//  Registers a one-hot grant and drives the mux selects s1/s0 from the winning index.
//  Gates the mux output with a valid flag. Sits between requester logic and mux4_1.
// PARAMETERS
//  MAX_HOLD  8  max consecutive GRANT cycles per grant when HOLD_LIMIT_EN defined; legal 2..15
//  CNT_W     4  hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  reset, asynchronous assert, active-low
//  req        in   4  request per requester; held high for as long as mux access is needed
//  in         in   4  data bit per requester; in[i] feeds mux input i
//  gnt        out  4  registered one-hot grant; 0000 = no owner
//  s1, s0     out  1  registered mux selects; {s1,s0} = granted index
//  out_valid  out  1  registered; equals |gnt
//  out        out  1  mux4_1 output AND out_valid (combinational from in)
// BEHAVIOUR
//  Reset (rst_n=0, async): gnt=0000, s1=s0=0, out_valid=0, state=IDLE, hold_cnt=0,
//   last=3, so requester 0 has first priority after reset. Reset mid-grant clears all at once.
//  FSM states: IDLE (no owner) and GRANT (gnt one-hot). Single always block plus next-index logic.
//  Winner = first set req bit scanning (last+1)%4, (last+2)%4, ..., last. On each new grant,
//   last <= winner and hold_cnt <= 0.
//  IDLE: req==0000 -> stay in IDLE. Otherwise -> GRANT with the winner on the next edge (1-cycle latency).
//  GRANT, req[owner]=1 -> keep the grant; hold_cnt increments (saturates at MAX_HOLD-1).
//  GRANT, req[owner]=0 and another req set -> grant the next winner on the same edge (no idle bubble).
//  GRANT, req[owner]=0 and no other req -> IDLE; gnt=0000; s1/s0 keep their last value; out_valid=0.
//  The owner reasserting req after release ranks last in the rotation.
//  Simultaneous release and new requests are resolved by the rotation above in one edge.
//  out = 0 whenever out_valid=0. When granted, out = in[{s1,s0}] with zero added latency.
// CONFIGURATION
//  Macro HOLD_LIMIT_EN defined: in GRANT, when hold_cnt==MAX_HOLD-1 and another req is set,
//   the owner is preempted on that edge and the next winner is granted.
//   If no other req is set, the owner keeps the grant and hold_cnt stays saturated.
//  Macro not defined: no preemption; the grant lasts until the owner drops req.
//   hold_cnt is not instantiated; MAX_HOLD and CNT_W are unused.
// STRUCTURE
//  Shared package mux_arb_pkg:
//   - NREQ=4
//   - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
//   - function rr_next(req, last) returning the 2-bit winner index
//  Sub-module: one mux4_1 instance (out, in[0..3], s0, s1); its output is ANDed with out_valid.
// TESTING
//  1 Reset: rst_n=0 with req=1111 -> gnt=0000, {s1,s0}=00, out_valid=0, out=0.
//  2 in=0101, req=0001 -> one edge later gnt=0001, {s1,s0}=00, out_valid=1, out=1;
//    drop req -> next edge gnt=0000, out=0.
//  3 req=1111, each owner drops its req 2 cycles after its grant then reasserts ->
//    grant order 0,1,2,3,0 with no idle cycle between grants.
//  4 HOLD_LIMIT_EN, MAX_HOLD=4, req=0011 held -> gnt=0001 for 4 cycles, 0010 for 4, then 0001 again.
//  5 HOLD_LIMIT_EN, req=0001 held for 20 cycles -> gnt stays 0001.
//    Macro undefined with test 4 stimulus -> gnt stays 0001 throughout.
//  6 Grant held at 0100; pulse rst_n low mid-cycle -> gnt=0000 before the next edge.
//    Then release reset with req=0110 -> gnt=0010 (pointer reset to last=3).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin mux arbiter: requester count, FSM
// state encoding and the rotating-priority winner function.
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int unsigned NREQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Winner = first set bit scanning (last+1), (last+2), ..., last (mod 4).
    // The scan runs from the farthest offset down so the nearest set bit is
    // written last and wins. Returns last when no request is set.
    function automatic logic [1:0] rr_next(input logic [NREQ-1:0] req,
                                           input logic [1:0]      last);
        logic [1:0] idx;
        rr_next = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mux4_1.sv
// -----------------------------------------------------------------------------
// mux4_1
// Single-bit 4:1 multiplexer.
// Ports:
//   o_out  out  selected data bit, i_in[{i_s1,i_s0}]
//   i_in   in   4 data bits
//   i_s0   in   select bit 0
//   i_s1   in   select bit 1
// -----------------------------------------------------------------------------
module mux4_1 (
    output logic       o_out,
    input  logic [3:0] i_in,
    input  logic       i_s0,
    input  logic       i_s1
);

    always_comb begin
        o_out = 1'b0;
        unique case ({i_s1, i_s0})
            2'b00:   o_out = i_in[0];
            2'b01:   o_out = i_in[1];
            2'b10:   o_out = i_in[2];
            2'b11:   o_out = i_in[3];
            default: o_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing one mux4_1 among four requesters. The grant is a
// registered one-hot vector, the mux selects are the registered winner index,
// and the mux output is gated with the registered valid flag.
//
// Optional feature: define HOLD_LIMIT_EN to preempt an owner that has held the
// grant for MAX_HOLD consecutive cycles while another requester is waiting.
// Without the macro the hold counter is not built and the grant lasts until the
// owner drops its request.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req[3:0]   in   per-requester request, held while access is needed
//   in[3:0]    in   per-requester data bit, in[i] feeds mux input i
//   gnt[3:0]   out  registered one-hot grant, 0000 = no owner
//   s1, s0     out  registered mux selects, {s1,s0} = granted index
//   out_valid  out  registered, equals |gnt
//   out        out  mux output AND out_valid (combinational from in)
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] in,
    output logic [NREQ-1:0] gnt,
    output logic            s1,
    output logic            s0,
    output logic            out_valid,
    output logic            out
);

    // Reject illegal configurations at elaboration.
    if (MAX_HOLD < 2 || MAX_HOLD > 15 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("mux4_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    arb_state_e      r_state;
    logic [NREQ-1:0] r_gnt;
    logic            r_s1;
    logic            r_s0;
    logic            r_valid;
    logic [1:0]      r_last;   // index of the most recent winner (current owner in GRANT)
`ifdef HOLD_LIMIT_EN
    logic [CNT_W-1:0] r_hold_cnt;
`endif

    logic [1:0]      w_winner;
    logic [NREQ-1:0] w_owner_oh;
    logic            w_owner_req;
    logic            w_others;
    logic            w_new_grant;
    logic            w_release;
    logic            w_mux_out;

    assign w_winner    = rr_next(req, r_last);
    assign w_owner_oh  = 4'b0001 << r_last;
    assign w_owner_req = req[r_last];
    assign w_others    = |(req & ~w_owner_oh);

    // Owner sits last in the scan, so when another request is set the winner is
    // never the current owner; this covers both handover and preemption.
    always_comb begin
        w_new_grant = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_new_grant = |req;
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    w_new_grant = w_others;
                    w_release   = !w_others;
                end
`ifdef HOLD_LIMIT_EN
                else if (w_others && (r_hold_cnt == CNT_W'(MAX_HOLD - 1))) begin
                    w_new_grant = 1'b1;
                end
`endif
            end
            default: begin
                w_new_grant = 1'b0;
                w_release   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_s1       <= 1'b0;
            r_s0       <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 2'd3;
`ifdef HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else if (w_new_grant) begin
            r_state    <= ST_GRANT;
            r_gnt      <= 4'b0001 << w_winner;
            r_s1       <= w_winner[1];
            r_s0       <= w_winner[0];
            r_valid    <= 1'b1;
            r_last     <= w_winner;
`ifdef HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else if (w_release) begin
            // Selects intentionally keep their last value.
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end
`ifdef HOLD_LIMIT_EN
        else if (r_state == ST_GRANT && r_hold_cnt != CNT_W'(MAX_HOLD - 1)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
`endif
    end

    mux4_1 u_mux (
        .o_out (w_mux_out),
        .i_in  (in),
        .i_s0  (r_s0),
        .i_s1  (r_s1)
    );

    assign gnt       = r_gnt;
    assign s1        = r_s1;
    assign s0        = r_s0;
    assign out_valid = r_valid;
    assign out       = w_mux_out & r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       s1, s0, out_valid, dout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: who owns the mux, rotation pointer, hold age.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_hold;
    int m_sel;

    mux4_rr_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in        (din),
        .gnt       (gnt),
        .s1        (s1),
        .s0        (s0),
        .out_valid (out_valid),
        .out       (dout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = 3;
        m_hold  = 0;
        m_sel   = 0;
    endtask

    task automatic model_take(input int w);
        m_busy  = 1;
        m_owner = w;
        m_last  = w;
        m_hold  = 0;
        m_sel   = w;
    endtask

    // One clock edge of the arbitration rules, applied to the current req.
    task automatic model_edge();
        bit others;
        if (!m_busy) begin
            if (req != 4'b0) model_take(pick(req, m_last));
        end else begin
            others = 1'b0;
            for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) others = 1'b1;
            if (req[m_owner]) begin
`ifdef HOLD_LIMIT_EN
                if (others && m_hold == MAX_HOLD - 1) model_take(pick(req, m_last));
                else if (m_hold < MAX_HOLD - 1) m_hold++;
`else
                m_hold++;
`endif
            end else if (others) begin
                model_take(pick(req, m_last));
            end else begin
                m_busy = 0;
            end
        end
    endtask

    task automatic compare();
        check_eq("gnt", gnt, m_busy ? (32'd1 << m_owner) : 32'd0);
        check_eq("sel", {s1, s0}, m_sel);
        check_eq("out_valid", out_valid, m_busy);
        check_eq("out", dout, m_busy ? din[m_sel] : 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // Reset with the given request pattern applied, checked while in reset.
    task automatic do_reset(input logic [3:0] r);
        @(negedge clk);
        rst_n = 1'b0;
        req   = r;
        #1;
        model_reset();
        check_eq("rst_gnt", gnt, 4'b0000);
        check_eq("rst_sel", {s1, s0}, 2'b00);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_out", dout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  ngr;
        int  age;
        logic [3:0] prev;
        rst_n = 1'b0;
        req   = 4'b0;
        din   = 4'b0;
        model_reset();

        // Reset with every requester asserted.
        din = 4'b1111;
        do_reset(4'b1111);

        // Single requester: grant, data through mux, release.
        do_reset(4'b0000);
        din = 4'b0101;
        req = 4'b0001;
        step();
        check_eq("t2_gnt", gnt, 4'b0001);
        check_eq("t2_out", dout, 1'b1);
        req = 4'b0000;
        step();
        check_eq("t2_rel_gnt", gnt, 4'b0000);
        check_eq("t2_rel_out", dout, 1'b0);

        // Rotation: each owner drops after 2 cycles then reasserts.
        do_reset(4'b1111);
        ngr  = 0;
        age  = 0;
        prev = 4'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            check_eq("t3_no_bubble", out_valid, 1'b1);
            if (gnt != prev) begin
                check_eq("t3_order", gnt, 32'd1 << (ngr % 4));
                ngr++;
                age = 1;
            end else begin
                age++;
            end
            prev = gnt;
            req  = (age == 2) ? (4'b1111 & ~(4'b0001 << m_owner)) : 4'b1111;
        end
        check_eq("t3_grants", ngr, 6);

        // Two requesters held: preemption pattern or a single owner.
        do_reset(4'b0011);
        for (int c = 0; c < 12; c++) begin
            step();
`ifdef HOLD_LIMIT_EN
            check_eq("t4_seq", gnt, ((c / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
`else
            check_eq("t4_seq", gnt, 4'b0001);
`endif
        end

        // Lone requester keeps the grant indefinitely.
        do_reset(4'b0001);
        for (int c = 0; c < 20; c++) begin
            step();
            check_eq("t5_hold", gnt, 4'b0001);
        end

        // Async reset mid-grant, then pointer restarts at last=3.
        do_reset(4'b0100);
        step();
        step();
        check_eq("t6_pre", gnt, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_gnt", gnt, 4'b0000);
        check_eq("t6_async_valid", out_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0110;
        step();
        check_eq("t6_after", gnt, 4'b0010);

        // Randomized traffic against the model.
        do_reset(4'b0000);
        for (int c = 0; c < 500; c++) begin
            din = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
